line_clear_ctrl: RTL and testbench

- Sequences row clearing after a piece locks.
- On a start pulse it snapshots the occupancy bitmap and colour playfield, then scans rows bottom-to-top.
- Each full row is removed by shifting everything above it down one row, one full row per cycle.
- It counts lines cleared per pass, accumulates a score, and returns the compacted playfield to the game FSM with a done pulse.

---
 rtl/line_clear_ctrl_pkg.sv | 39 +++
 rtl/line_clear_ctrl_if.sv | 27 ++
 rtl/line_clear_ctrl_shift.sv | 30 +++
 rtl/line_clear_ctrl.sv | 117 +++++++++++
 tb/tb_line_clear_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// rtl/line_clear_ctrl_pkg.sv - shared playfield geometry, state/colour types and scoring table
package tetris_pkg;

  localparam int PLAY_WIDTH  = 10;
  localparam int PLAY_HEIGHT = 15;
  localparam int N_CELLS     = PLAY_WIDTH * PLAY_HEIGHT;
  localparam int ROW_W       = $clog2(PLAY_HEIGHT);

  localparam int PTS_1 = 40;
  localparam int PTS_2 = 100;
  localparam int PTS_3 = 300;
  localparam int PTS_4 = 1200;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} clr_state_t;

  typedef logic [2:0] cell_t;

  // Points awarded for one pass; four or more lines all earn the top award.
  function automatic logic [10:0] points(input logic [3:0] n);
    case (n)
      4'd0:    points = 11'd0;
      4'd1:    points = 11'(PTS_1);
      4'd2:    points = 11'(PTS_2);
      4'd3:    points = 11'(PTS_3);
      default: points = 11'(PTS_4);
    endcase
  endfunction

  // True when every cell of the selected row is occupied.
  function automatic logic row_full(input logic [N_CELLS-1:0] bg, input logic [ROW_W-1:0] row);
    logic full;
    full = 1'b0;
    for (int r = 0; r < PLAY_HEIGHT; r++) begin
      if (row == ROW_W'(r)) full = &bg[r*PLAY_WIDTH +: PLAY_WIDTH];
    end
    return full;
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// rtl/line_clear_ctrl_if.sv - game FSM <-> line clear controller handshake and playfield bus
interface line_clear_ctrl_if #(
  parameter int SCORE_W = 20
);
  import tetris_pkg::*;

  logic               start;
  logic [N_CELLS-1:0] bg_in;
  cell_t              color_in [0:N_CELLS-1];
  logic               busy;
  logic               done;
  logic [N_CELLS-1:0] bg_out;
  cell_t              color_out [0:N_CELLS-1];
  logic [3:0]         lines_cleared;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, bg_in, color_in,
    input  busy, done, bg_out, color_out, lines_cleared, score
  );

  modport slave (
    input  start, bg_in, color_in,
    output busy, done, bg_out, color_out, lines_cleared, score
  );

endinterface

// File: rtl/line_clear_ctrl_shift.sv
// rtl/line_clear_ctrl_shift.sv - combinational drop of rows 0..i_row by one row, row 0 emptied
module line_shift_unit
  import tetris_pkg::*;
(
  input  logic [N_CELLS-1:0] i_bg,
  input  cell_t              i_color [0:N_CELLS-1],
  input  logic [ROW_W-1:0]   i_row,
  output logic [N_CELLS-1:0] o_bg,
  output cell_t              o_color [0:N_CELLS-1]
);

  // Rows 1..i_row take the row above them; row 0 always empties; rows below i_row pass through.
  always_comb begin
    o_bg    = i_bg;
    o_color = i_color;
    for (int c = 0; c < PLAY_WIDTH; c++) begin
      o_bg[c]    = 1'b0;
      o_color[c] = '0;
    end
    for (int r = 1; r < PLAY_HEIGHT; r++) begin
      if (ROW_W'(r) <= i_row) begin
        for (int c = 0; c < PLAY_WIDTH; c++) begin
          o_bg[r*PLAY_WIDTH + c]    = i_bg[(r-1)*PLAY_WIDTH + c];
          o_color[r*PLAY_WIDTH + c] = i_color[(r-1)*PLAY_WIDTH + c];
        end
      end
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - row-clear sequencer: snapshot, bottom-up scan, compaction, scoring
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  line_clear_ctrl_if.slave bus
);

  clr_state_t         r_state;
  logic [ROW_W-1:0]   r_row_ptr;
  logic [3:0]         r_count;
  logic [N_CELLS-1:0] r_bg;
  cell_t              r_color [0:N_CELLS-1];
  logic               r_busy;
  logic               r_done;
  logic [3:0]         r_lines;
  logic [SCORE_W-1:0] r_score;

  logic [N_CELLS-1:0] w_shift_bg;
  cell_t              w_shift_color [0:N_CELLS-1];
  logic               w_check_full;
  logic               w_shift_full;
  logic [3:0]         w_count_inc;
  logic [3:0]         w_done_count;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_next;

  line_shift_unit u_shift (
    .i_bg    (r_bg),
    .i_color (r_color),
    .i_row   (r_row_ptr),
    .o_bg    (w_shift_bg),
    .o_color (w_shift_color)
  );

  // The SHIFT cycle re-checks the same row on the freshly shifted data, so each
  // cleared line costs exactly one extra cycle instead of a shift plus a re-check.
  assign w_check_full = row_full(r_bg, r_row_ptr);
  assign w_shift_full = row_full(w_shift_bg, r_row_ptr);
  assign w_count_inc  = (r_count == 4'hF) ? r_count : r_count + 4'd1;
  assign w_done_count = (r_state == SHIFT) ? w_count_inc : r_count;
  assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(points(w_done_count));
  assign w_score_next = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.bg_out        = r_bg;
  assign bus.color_out     = r_color;
  assign bus.lines_cleared = r_lines;
  assign bus.score         = r_score;

  // Pass sequencer; done/lines/score are loaded on entry to DONE so they are valid in that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_row_ptr <= ROW_W'(PLAY_HEIGHT-1);
      r_count   <= 4'd0;
      r_bg      <= '0;
      for (int i = 0; i < N_CELLS; i++) r_color[i] <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_lines   <= 4'd0;
      r_score   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bg      <= bus.bg_in;
            r_color   <= bus.color_in;
            r_row_ptr <= ROW_W'(PLAY_HEIGHT-1);
            r_count   <= 4'd0;
            r_busy    <= 1'b1;
            r_state   <= CHECK;
          end
        end
        CHECK: begin
          if (w_check_full) begin
            r_state <= SHIFT;
          end else if (r_row_ptr == '0) begin
            r_done  <= 1'b1;
            r_lines <= w_done_count;
            r_score <= w_score_next;
            r_state <= DONE;
          end else begin
            r_row_ptr <= r_row_ptr - 1'b1;
          end
        end
        SHIFT: begin
          r_bg    <= w_shift_bg;
          r_color <= w_shift_color;
          r_count <= w_count_inc;
          if (w_shift_full) begin
            r_state <= SHIFT;
          end else if (r_row_ptr == '0) begin
            r_done  <= 1'b1;
            r_lines <= w_done_count;
            r_score <= w_score_next;
            r_state <= DONE;
          end else begin
            r_row_ptr <= r_row_ptr - 1'b1;
            r_state   <= CHECK;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - self-checking bench for line_clear_ctrl
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int SW   = 20;
  localparam int SMAX = (1 << SW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  line_clear_ctrl_if #(.SCORE_W(SW)) bus ();
  line_clear_ctrl #(.SCORE_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic int pts(input int k);
    if (k == 0) return 0;
    if (k == 1) return 40;
    if (k == 2) return 100;
    if (k == 3) return 300;
    return 1200;
  endfunction

  // Model: full rows are dropped, survivors keep their order and settle at the bottom.
  logic [N_CELLS-1:0] m_bg;
  cell_t              m_col [0:N_CELLS-1];
  bit                 m_active = 1'b0;
  int                 m_k = 0, m_lat = 0, m_cyc = 0, m_score = 0, m_lines = 0;

  always @(negedge clk) begin : cmp
    int  bad;
    int  dst;
    bit  full;
    bit  exp_done;
    if (!reset) begin
      m_active = 1'b0;
      m_score  = 0;
      m_lines  = 0;
      bad = 0;
      for (int i = 0; i < N_CELLS; i++) if (bus.color_out[i] !== 3'd0) bad++;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_score", bus.score, '0);
      chk("rst_lines", bus.lines_cleared, '0);
      chk("rst_bg", bus.bg_out, '0);
      chk("rst_color_bad_cells", bad, 0);
    end else begin
      if (!m_active && bus.start) begin
        m_bg = '0;
        for (int i = 0; i < N_CELLS; i++) m_col[i] = '0;
        m_k = 0;
        dst = PLAY_HEIGHT - 1;
        for (int r = PLAY_HEIGHT - 1; r >= 0; r--) begin
          full = 1'b1;
          for (int c = 0; c < PLAY_WIDTH; c++) if (!bus.bg_in[r*PLAY_WIDTH + c]) full = 1'b0;
          if (full) m_k++;
          else begin
            for (int c = 0; c < PLAY_WIDTH; c++) begin
              m_bg[dst*PLAY_WIDTH + c]  = bus.bg_in[r*PLAY_WIDTH + c];
              m_col[dst*PLAY_WIDTH + c] = bus.color_in[r*PLAY_WIDTH + c];
            end
            dst--;
          end
        end
        if (m_k > 15) m_k = 15;
        m_lat    = PLAY_HEIGHT + m_k + 1;
        m_cyc    = 1;
        m_active = 1'b1;
      end else if (m_active) begin
        m_cyc++;
      end
      exp_done = m_active && (m_cyc == m_lat);
      chk("busy", bus.busy, m_active);
      chk("done", bus.done, exp_done);
      if (exp_done) begin
        m_score = m_score + pts(m_k);
        if (m_score > SMAX) m_score = SMAX;
        m_lines = m_k;
        bad = 0;
        for (int i = 0; i < N_CELLS; i++) if (bus.color_out[i] !== m_col[i]) bad++;
        chk("done_bg", bus.bg_out, m_bg);
        chk("done_color_bad_cells", bad, 0);
        chk("done_lines", bus.lines_cleared, m_lines);
        m_active = 1'b0;
      end
      chk("score", bus.score, m_score);
      if (!m_active) chk("lines_held", bus.lines_cleared, m_lines);
    end
  end

  task automatic clear_board();
    bus.bg_in = '0;
    for (int i = 0; i < N_CELLS; i++) bus.color_in[i] = '0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < PLAY_WIDTH; c++) begin
      bus.bg_in[r*PLAY_WIDTH + c]    = 1'b1;
      bus.color_in[r*PLAY_WIDTH + c] = cell_t'((c % 7) + 1);
    end
  endtask

  task automatic put(input int r, input int c, input cell_t col);
    bus.bg_in[r*PLAY_WIDTH + c]    = 1'b1;
    bus.color_in[r*PLAY_WIDTH + c] = col;
  endtask

  task automatic run_pass(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    #1 bus.start = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = bus.done;
      if (lat == 1) #1 bus.start = 1'b0;
    end
    chk("done_seen", got, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idle_busy", bus.busy, 1'b0);
    chk("rst_idle_score", bus.score, '0);
    chk("rst_idle_bg", bus.bg_out, '0);
    #1 reset = 1'b1;
  endtask

  initial begin : stim
    int lat;
    bit saw;
    logic [N_CELLS-1:0] exp_bg;
    bus.start = 1'b0;
    clear_board();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // bottom row full, one cell above it
    fill_row(14); put(13, 3, 3'd5);
    run_pass(lat);
    exp_bg = '0; exp_bg[143] = 1'b1;
    chk("t2_latency", lat, 17);
    chk("t2_bg", bus.bg_out, exp_bg);
    chk("t2_color", bus.color_out[143], 3'd5);
    chk("t2_lines", bus.lines_cleared, 4'd1);
    chk("t2_score", bus.score, 20'd40);

    // reset while idle, then an empty board
    do_reset();
    clear_board();
    run_pass(lat);
    chk("t1_latency", lat, 16);
    chk("t1_lines", bus.lines_cleared, 4'd0);
    chk("t1_score", bus.score, 20'd0);

    // four stacked full rows
    do_reset();
    clear_board();
    for (int r = 11; r <= 14; r++) fill_row(r);
    put(10, 0, 3'd2);
    run_pass(lat);
    exp_bg = '0; exp_bg[140] = 1'b1;
    chk("t3_latency", lat, 20);
    chk("t3_bg", bus.bg_out, exp_bg);
    chk("t3_color", bus.color_out[140], 3'd2);
    chk("t3_lines", bus.lines_cleared, 4'd4);
    chk("t3_score", bus.score, 20'd1200);

    // non-adjacent full rows
    do_reset();
    clear_board();
    fill_row(14); fill_row(12); put(13, 5, 3'd1);
    run_pass(lat);
    exp_bg = '0; exp_bg[145] = 1'b1;
    chk("t4_latency", lat, 18);
    chk("t4_bg", bus.bg_out, exp_bg);
    chk("t4_color", bus.color_out[145], 3'd1);
    chk("t4_lines", bus.lines_cleared, 4'd2);
    chk("t4_score", bus.score, 20'd100);

    // only the top row full
    do_reset();
    clear_board();
    fill_row(0);
    run_pass(lat);
    chk("row0_latency", lat, 17);
    chk("row0_bg", bus.bg_out, '0);
    chk("row0_lines", bus.lines_cleared, 4'd1);

    // whole board full
    do_reset();
    clear_board();
    for (int r = 0; r < PLAY_HEIGHT; r++) fill_row(r);
    run_pass(lat);
    chk("full_latency", lat, 31);
    chk("full_bg", bus.bg_out, '0);
    chk("full_lines", bus.lines_cleared, 4'd15);
    chk("full_score", bus.score, 20'd1200);

    // start while busy, then reset mid-pass
    do_reset();
    clear_board();
    for (int r = 11; r <= 14; r++) fill_row(r);
    put(10, 0, 3'd2);
    @(negedge clk);
    #1 bus.start = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    #1 bus.start = 1'b1;
    clear_board();
    @(negedge clk);
    chk("t5_busy_c3", bus.busy, 1'b1);
    #1 bus.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_score", bus.score, '0);
    #1 reset = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) saw = 1'b1;
    end
    chk("t5_no_done", saw, 1'b0);
    clear_board();
    fill_row(14); put(13, 3, 3'd5);
    run_pass(lat);
    chk("t5_fresh_latency", lat, 17);
    chk("t5_fresh_lines", bus.lines_cleared, 4'd1);
    chk("t5_fresh_score", bus.score, 20'd40);

    // score saturation through repeated four-line passes
    do_reset();
    clear_board();
    for (int r = 11; r <= 14; r++) fill_row(r);
    for (int i = 1; i <= 875; i++) begin
      run_pass(lat);
      if (i == 873) chk("sat_below", bus.score, 20'd1047600);
      if (i >= 874) chk("sat_clamp", bus.score, 20'hFFFFF);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
